id_ex_stage_register: RTL and testbench

- Pipeline register between the decode stage (control unit, register file, immediate generator) and the execute stage of the hazard-controlled RISC-V core.
- Captures decoded control signals and operands every cycle.
- Detects load-use hazards against the instruction currently in EX. On a hazard it stalls PC and IF/ID and inserts a bubble.
- Supports a flush from branch resolution and keeps a saturating count of inserted stall bubbles.

---
 rtl/id_ex_stage_register.sv | 163 ++++++++++++++++
 tb/tb_id_ex_stage_register.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage_register.sv
// ID/EX pipeline register with load-use hazard detection, flush squash and a
// saturating count of inserted stall bubbles.
// Latency: ex_* outputs are valid one cycle after the id_* inputs; pc_write and
// if_id_write respond combinationally in the same cycle as the hazard.
// Backpressure: on a load-use hazard, PC and IF/ID are held for one cycle and a
// bubble (all controls zero) enters EX. A flush overrides the stall.
// Ports: id_* are decode-stage controls and operands in; ex_* are their registered
// copies out; flush squashes the decode instruction; stall_count counts bubbles.
module id_ex_stage_register #(
  parameter int DATA_WIDTH = 64,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  id_Branch,
  input  logic                  id_MemRead,
  input  logic                  id_MemtoReg,
  input  logic                  id_MemWrite,
  input  logic                  id_ALUSrc,
  input  logic                  id_RegWrite,
  input  logic [1:0]            id_ALUOp,
  input  logic [DATA_WIDTH-1:0] id_pc,
  input  logic [DATA_WIDTH-1:0] id_rs1_data,
  input  logic [DATA_WIDTH-1:0] id_rs2_data,
  input  logic [DATA_WIDTH-1:0] id_imm,
  input  logic [4:0]            id_rs1,
  input  logic [4:0]            id_rs2,
  input  logic [4:0]            id_rd,
  input  logic [3:0]            id_funct4,
  output logic                  ex_Branch,
  output logic                  ex_MemRead,
  output logic                  ex_MemtoReg,
  output logic                  ex_MemWrite,
  output logic                  ex_ALUSrc,
  output logic                  ex_RegWrite,
  output logic [1:0]            ex_ALUOp,
  output logic [DATA_WIDTH-1:0] ex_pc,
  output logic [DATA_WIDTH-1:0] ex_rs1_data,
  output logic [DATA_WIDTH-1:0] ex_rs2_data,
  output logic [DATA_WIDTH-1:0] ex_imm,
  output logic [4:0]            ex_rs1,
  output logic [4:0]            ex_rs2,
  output logic [4:0]            ex_rd,
  output logic [3:0]            ex_funct4,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic [CNT_WIDTH-1:0]  stall_count
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic                  branch_q,   branch_d;
  logic                  memread_q,  memread_d;
  logic                  memtoreg_q, memtoreg_d;
  logic                  memwrite_q, memwrite_d;
  logic                  alusrc_q,   alusrc_d;
  logic                  regwrite_q, regwrite_d;
  logic [1:0]            aluop_q,    aluop_d;
  logic [DATA_WIDTH-1:0] pc_q,       pc_d;
  logic [DATA_WIDTH-1:0] rs1_data_q, rs1_data_d;
  logic [DATA_WIDTH-1:0] rs2_data_q, rs2_data_d;
  logic [DATA_WIDTH-1:0] imm_q,      imm_d;
  logic [4:0]            rs1_q,      rs1_d;
  logic [4:0]            rs2_q,      rs2_d;
  logic [4:0]            rd_q,       rd_d;
  logic [3:0]            funct4_q,   funct4_d;
  logic [CNT_WIDTH-1:0]  stall_q,    stall_d;

  logic hazard;
  logic squash;

  // Both sources are compared regardless of opcode (conservative for I-type).
  // Flush masks the hazard so a squashed instruction never stalls the front end.
  assign hazard = memread_q & (rd_q != 5'd0) &
                  ((rd_q == id_rs1) | (rd_q == id_rs2)) & ~flush;
  assign squash = flush | hazard;

  assign pc_write    = ~hazard;
  assign if_id_write = ~hazard;

  always_comb begin
    branch_d   = id_Branch   & ~squash;
    memread_d  = id_MemRead  & ~squash;
    // Control unit leaves MemtoReg undefined when nothing is written back;
    // gating with RegWrite keeps that X out of the pipeline.
    memtoreg_d = id_MemtoReg & id_RegWrite & ~squash;
    memwrite_d = id_MemWrite & ~squash;
    alusrc_d   = id_ALUSrc   & ~squash;
    regwrite_d = id_RegWrite & ~squash;
    aluop_d    = squash ? 2'b00 : id_ALUOp;
    // Data and index fields always load; only the controls form the bubble.
    pc_d       = id_pc;
    rs1_data_d = id_rs1_data;
    rs2_data_d = id_rs2_data;
    imm_d      = id_imm;
    rs1_d      = id_rs1;
    rs2_d      = id_rs2;
    rd_d       = id_rd;
    funct4_d   = id_funct4;
    stall_d    = stall_q;
    if (hazard && (stall_q != CNT_MAX)) begin
      stall_d = stall_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      branch_q   <= 1'b0;
      memread_q  <= 1'b0;
      memtoreg_q <= 1'b0;
      memwrite_q <= 1'b0;
      alusrc_q   <= 1'b0;
      regwrite_q <= 1'b0;
      aluop_q    <= '0;
      pc_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      funct4_q   <= '0;
      stall_q    <= '0;
    end else begin
      branch_q   <= branch_d;
      memread_q  <= memread_d;
      memtoreg_q <= memtoreg_d;
      memwrite_q <= memwrite_d;
      alusrc_q   <= alusrc_d;
      regwrite_q <= regwrite_d;
      aluop_q    <= aluop_d;
      pc_q       <= pc_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      funct4_q   <= funct4_d;
      stall_q    <= stall_d;
    end
  end

  assign ex_Branch   = branch_q;
  assign ex_MemRead  = memread_q;
  assign ex_MemtoReg = memtoreg_q;
  assign ex_MemWrite = memwrite_q;
  assign ex_ALUSrc   = alusrc_q;
  assign ex_RegWrite = regwrite_q;
  assign ex_ALUOp    = aluop_q;
  assign ex_pc       = pc_q;
  assign ex_rs1_data = rs1_data_q;
  assign ex_rs2_data = rs2_data_q;
  assign ex_imm      = imm_q;
  assign ex_rs1      = rs1_q;
  assign ex_rs2      = rs2_q;
  assign ex_rd       = rd_q;
  assign ex_funct4   = funct4_q;
  assign stall_count = stall_q;

endmodule

// File: tb/tb_id_ex_stage_register.sv
module tb_id_ex_stage_register;

  logic        clk = 1'b0;
  logic        reset, flush;
  logic        id_Branch, id_MemRead, id_MemtoReg, id_MemWrite, id_ALUSrc, id_RegWrite;
  logic [1:0]  id_ALUOp;
  logic [63:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [3:0]  id_funct4;

  logic        ex_Branch, ex_MemRead, ex_MemtoReg, ex_MemWrite, ex_ALUSrc, ex_RegWrite;
  logic [1:0]  ex_ALUOp;
  logic [63:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [3:0]  ex_funct4;
  logic        pc_write, if_id_write;
  logic [31:0] stall_count;

  // Second instance with a 2-bit counter, driven by the same stimulus.
  logic        s_Branch, s_MemRead, s_MemtoReg, s_MemWrite, s_ALUSrc, s_RegWrite;
  logic [1:0]  s_ALUOp;
  logic [63:0] s_pc, s_rs1_data, s_rs2_data, s_imm;
  logic [4:0]  s_rs1, s_rs2, s_rd;
  logic [3:0]  s_funct4;
  logic        s_pc_write, s_if_id_write;
  logic [1:0]  s_stall_count;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] ex_ctrl;
  assign ex_ctrl = {ex_Branch, ex_MemRead, ex_MemtoReg, ex_MemWrite,
                    ex_ALUSrc, ex_RegWrite, ex_ALUOp};

  always #5 clk = ~clk;

  id_ex_stage_register #(.DATA_WIDTH(64), .CNT_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .id_Branch(id_Branch), .id_MemRead(id_MemRead), .id_MemtoReg(id_MemtoReg),
    .id_MemWrite(id_MemWrite), .id_ALUSrc(id_ALUSrc), .id_RegWrite(id_RegWrite),
    .id_ALUOp(id_ALUOp), .id_pc(id_pc), .id_rs1_data(id_rs1_data),
    .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_funct4(id_funct4),
    .ex_Branch(ex_Branch), .ex_MemRead(ex_MemRead), .ex_MemtoReg(ex_MemtoReg),
    .ex_MemWrite(ex_MemWrite), .ex_ALUSrc(ex_ALUSrc), .ex_RegWrite(ex_RegWrite),
    .ex_ALUOp(ex_ALUOp), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
    .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rd(ex_rd), .ex_funct4(ex_funct4),
    .pc_write(pc_write), .if_id_write(if_id_write), .stall_count(stall_count)
  );

  id_ex_stage_register #(.DATA_WIDTH(64), .CNT_WIDTH(2)) dut_sat (
    .clk(clk), .reset(reset), .flush(flush),
    .id_Branch(id_Branch), .id_MemRead(id_MemRead), .id_MemtoReg(id_MemtoReg),
    .id_MemWrite(id_MemWrite), .id_ALUSrc(id_ALUSrc), .id_RegWrite(id_RegWrite),
    .id_ALUOp(id_ALUOp), .id_pc(id_pc), .id_rs1_data(id_rs1_data),
    .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_funct4(id_funct4),
    .ex_Branch(s_Branch), .ex_MemRead(s_MemRead), .ex_MemtoReg(s_MemtoReg),
    .ex_MemWrite(s_MemWrite), .ex_ALUSrc(s_ALUSrc), .ex_RegWrite(s_RegWrite),
    .ex_ALUOp(s_ALUOp), .ex_pc(s_pc), .ex_rs1_data(s_rs1_data),
    .ex_rs2_data(s_rs2_data), .ex_imm(s_imm), .ex_rs1(s_rs1), .ex_rs2(s_rs2),
    .ex_rd(s_rd), .ex_funct4(s_funct4),
    .pc_write(s_pc_write), .if_id_write(s_if_id_write), .stall_count(s_stall_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    {id_Branch, id_MemRead, id_MemtoReg, id_MemWrite, id_ALUSrc, id_RegWrite} = '0;
    id_ALUOp = 2'b00; id_pc = '0; id_rs1_data = '0; id_rs2_data = '0; id_imm = '0;
    id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_funct4 = '0;
  endtask

  task automatic load(input logic [4:0] rd);
    nop();
    id_MemRead = 1'b1; id_MemtoReg = 1'b1; id_RegWrite = 1'b1; id_ALUSrc = 1'b1;
    id_rs1 = 5'd2; id_rd = rd; id_pc = 64'h100; id_imm = 64'h8;
  endtask

  task automatic add(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
    nop();
    id_RegWrite = 1'b1; id_ALUOp = 2'b10;
    id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_pc = 64'h104; id_rs1_data = 64'hAA;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0;
    nop();
    // Arbitrary non-zero decode inputs while reset is held.
    load(5'd7); id_rs1 = 5'd7; id_rs2 = 5'd7; id_Branch = 1'b1; id_MemWrite = 1'b1;
    id_ALUOp = 2'b11; id_rs1_data = 64'h1234; id_funct4 = 4'hF;
    #1;
    tick();
    tick();
    check("rst_ctrl",     ex_ctrl, 8'h00);
    check("rst_pc",       ex_pc, 64'h0);
    check("rst_rs1_data", ex_rs1_data, 64'h0);
    check("rst_rd",       ex_rd, 5'd0);
    check("rst_funct4",   ex_funct4, 4'h0);
    check("rst_count",    stall_count, 32'd0);
    check("rst_pc_write", pc_write, 1'b1);
    check("rst_ifid_wr",  if_id_write, 1'b1);

    // R-type pass-through.
    reset = 1'b0;
    nop();
    id_RegWrite = 1'b1; id_ALUOp = 2'b10; id_rs1_data = 64'h11; id_rs2_data = 64'h22;
    id_rd = 5'd5; id_rs1 = 5'd1; id_rs2 = 5'd2; id_pc = 64'h40; id_funct4 = 4'b1000;
    tick();
    check("rtype_regwrite", ex_RegWrite, 1'b1);
    check("rtype_aluop",    ex_ALUOp, 2'b10);
    check("rtype_rs1_data", ex_rs1_data, 64'h11);
    check("rtype_rs2_data", ex_rs2_data, 64'h22);
    check("rtype_rd",       ex_rd, 5'd5);
    check("rtype_memtoreg", ex_MemtoReg, 1'b0);
    check("rtype_pc",       ex_pc, 64'h40);
    check("rtype_funct4",   ex_funct4, 4'b1000);

    // Load-use on rs2: one stall cycle, one bubble, then the add enters EX.
    load(5'd7);
    #1;
    check("ld_no_stall", pc_write, 1'b1);
    tick();
    check("ld_in_ex", ex_ctrl, 8'b0110_1100);
    add(5'd3, 5'd7, 5'd9);
    #1;
    check("lu_pc_write",   pc_write, 1'b0);
    check("lu_if_id_write", if_id_write, 1'b0);
    tick();
    check("lu_bubble_ctrl", ex_ctrl, 8'h00);
    check("lu_bubble_rd",   ex_rd, 5'd9);
    check("lu_count",       stall_count, 32'd1);
    check("lu_release",     pc_write, 1'b1);
    tick();
    check("lu_add_ctrl",  ex_ctrl, 8'b0000_0110);
    check("lu_add_rs2",   ex_rs2, 5'd7);
    check("lu_count_hold", stall_count, 32'd1);

    // ld x0 then add reading x0: never a hazard.
    load(5'd0);
    tick();
    add(5'd0, 5'd0, 5'd4);
    #1;
    check("x0_pc_write", pc_write, 1'b1);
    tick();
    check("x0_add_ctrl", ex_ctrl, 8'b0000_0110);
    check("x0_count",    stall_count, 32'd1);

    // ld x7 then add reading x8: no match.
    load(5'd7);
    tick();
    add(5'd8, 5'd8, 5'd4);
    #1;
    check("nomatch_pc_write", if_id_write, 1'b1);
    tick();
    check("nomatch_count", stall_count, 32'd1);

    // Flush coincident with a load-use hazard: flush wins, no count.
    load(5'd7);
    tick();
    add(5'd7, 5'd1, 5'd12);
    flush = 1'b1;
    #1;
    check("fl_pc_write",    pc_write, 1'b1);
    check("fl_if_id_write", if_id_write, 1'b1);
    tick();
    flush = 1'b0;
    check("fl_ctrl",  ex_ctrl, 8'h00);
    check("fl_rd",    ex_rd, 5'd12);
    check("fl_count", stall_count, 32'd1);

    // Store: MemtoReg asserted but RegWrite low must not be captured.
    nop();
    id_MemWrite = 1'b1; id_ALUSrc = 1'b1; id_MemtoReg = 1'b1; id_RegWrite = 1'b0;
    id_rs1 = 5'd2; id_rs2 = 5'd3; id_imm = 64'h10;
    tick();
    check("st_memtoreg", ex_MemtoReg, 1'b0);
    check("st_ctrl",     ex_ctrl, 8'b0001_1000);
    check("st_imm",      ex_imm, 64'h10);

    // Reset asserted mid-stall clears EX and releases the stall.
    load(5'd7);
    tick();
    add(5'd7, 5'd7, 5'd3);
    #1;
    check("mid_stall", pc_write, 1'b0);
    reset = 1'b1;
    tick();
    check("mid_rst_ctrl",  ex_ctrl, 8'h00);
    check("mid_rst_rd",    ex_rd, 5'd0);
    check("mid_rst_count", stall_count, 32'd0);
    check("mid_rst_pcw",   pc_write, 1'b1);
    reset = 1'b0;

    // Five load-use bubbles: 32-bit counter reaches 5, 2-bit counter stops at 3.
    for (int k = 0; k < 5; k++) begin
      load(5'd7);
      tick();
      add(5'd7, 5'd0, 5'd6);
      tick();
      if (k == 2) begin
        check("sat_at_3", s_stall_count, 2'd3);
      end
    end
    check("sat_wide_count", stall_count, 32'd5);
    check("sat_narrow",     s_stall_count, 2'd3);
    check("sat_bubble",     ex_ctrl, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Hard bound so the run always terminates.
  initial begin
    #20000;
    $display("FAIL timeout: observed no finish, expected finish within bound");
    $fatal(1, "timeout");
  end

endmodule
